baud_gen_frac: RTL and testbench

//  Programmable fractional baud-rate generator, successor to the fixed-divisor tick generator.

---
 rtl/baud_gen_frac.sv | 110 +++++++++++
 tb/tb_baud_gen_frac.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator: sample_tick at div_int + div_frac/2^FRAC_BITS clocks average,
// with bit_tick / mid_tick derived from an oversample counter and a shadowed divisor.
module baud_gen_frac #(
  parameter int DIV_WIDTH    = 16,
  parameter int FRAC_BITS    = 4,
  parameter int OVERSAMPLE   = 16,
  parameter int DEF_DIV_INT  = 81,
  parameter int DEF_DIV_FRAC = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 resync,
  input  logic                 div_wr,
  input  logic [DIV_WIDTH-1:0] div_int,
  input  logic [FRAC_BITS-1:0] div_frac,
  output logic                 sample_tick,
  output logic                 bit_tick,
  output logic                 mid_tick,
  output logic                 cfg_pending,
  output logic                 cfg_err
);

  localparam int OW = $clog2(OVERSAMPLE);
  localparam logic [OW-1:0]        OS_LAST  = OW'(OVERSAMPLE - 1);
  localparam logic [OW-1:0]        OS_MID   = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [OW-1:0]        OS_ONE   = OW'(1);
  localparam logic [DIV_WIDTH:0]   CNT_ONE  = (DIV_WIDTH + 1)'(1);
  localparam logic [DIV_WIDTH-1:0] DEF_INT  = DIV_WIDTH'(DEF_DIV_INT);
  localparam logic [FRAC_BITS-1:0] DEF_FRAC = FRAC_BITS'(DEF_DIV_FRAC);

  logic [DIV_WIDTH:0]   cnt;
  logic [DIV_WIDTH:0]   per;
  logic [FRAC_BITS-1:0] acc;
  logic [OW-1:0]        os_cnt;
  logic [DIV_WIDTH-1:0] int_cur;
  logic [FRAC_BITS-1:0] frac_cur;
  logic [DIV_WIDTH-1:0] sh_int;
  logic [FRAC_BITS-1:0] sh_frac;

  logic                 tick_edge;
  logic                 apply;
  logic                 wr_ok;
  logic [FRAC_BITS:0]   acc_sum;
  logic [DIV_WIDTH:0]   per_next;

  always_comb begin
    tick_edge = enable && !resync && (cnt == (per - CNT_ONE));
    apply     = cfg_pending && (tick_edge || !enable || resync);
    wr_ok     = (div_int != '0);
    acc_sum   = {1'b0, acc} + {1'b0, frac_cur};
    // the fractional carry stretches the next period by one clock
    per_next  = {1'b0, int_cur} + {{DIV_WIDTH{1'b0}}, acc_sum[FRAC_BITS]};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt         <= '0;
      per         <= {1'b0, DEF_INT};
      acc         <= '0;
      os_cnt      <= '0;
      int_cur     <= DEF_INT;
      frac_cur    <= DEF_FRAC;
      sh_int      <= '0;
      sh_frac     <= '0;
      sample_tick <= 1'b0;
      bit_tick    <= 1'b0;
      mid_tick    <= 1'b0;
      cfg_pending <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      sample_tick <= tick_edge;
      bit_tick    <= tick_edge && (os_cnt == OS_LAST);
      mid_tick    <= tick_edge && (os_cnt == OS_MID);
      cfg_err     <= div_wr && !wr_ok;

      if (resync) begin
        cnt    <= '0;
        os_cnt <= '0;
        acc    <= '0;
        per    <= {1'b0, int_cur};
      end else if (tick_edge) begin
        cnt    <= '0;
        acc    <= acc_sum[FRAC_BITS-1:0];
        per    <= per_next;
        os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_ONE;
      end else if (enable) begin
        cnt <= cnt + CNT_ONE;
      end

      // switchover overrides the period bookkeeping above; os_cnt keeps its phase
      if (apply) begin
        int_cur  <= sh_int;
        frac_cur <= sh_frac;
        per      <= {1'b0, sh_int};
        acc      <= '0;
        cnt      <= '0;
      end

      if (div_wr && wr_ok) begin
        sh_int      <= div_int;
        sh_frac     <= div_frac;
        cfg_pending <= 1'b1;
      end else if (apply) begin
        cfg_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed bench for baud_gen_frac: defaults, divisor switchover, error writes,
// enable/resync phase handling and mid-operation reset.
module tb_baud_gen_frac;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        resync = 1'b0;
  logic        div_wr = 1'b0;
  logic [15:0] div_int = 16'd0;
  logic [3:0]  div_frac = 4'd0;
  logic        sample_tick, bit_tick, mid_tick, cfg_pending, cfg_err;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  baud_gen_frac dut (
    .clk(clk), .reset(reset), .enable(enable), .resync(resync),
    .div_wr(div_wr), .div_int(div_int), .div_frac(div_frac),
    .sample_tick(sample_tick), .bit_tick(bit_tick), .mid_tick(mid_tick),
    .cfg_pending(cfg_pending), .cfg_err(cfg_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // clocks until the next observed sample_tick; -1 if none within the bound
  task automatic wait_tick(output int n);
    bit found;
    found = 1'b0;
    n = -1;
    for (int i = 1; i <= 200 && !found; i++) begin
      step();
      if (sample_tick) begin
        n = i;
        found = 1'b1;
      end
    end
  endtask

  task automatic write_div(input int vi, input int vf);
    div_int  = vi[15:0];
    div_frac = vf[3:0];
    div_wr   = 1'b1;
    step();
    div_wr   = 1'b0;
  endtask

  // intervals after tick i (i=1..16) with 81/6: carries land on adds 3,6,8 of every 8
  int gaps[16] = '{81,81,82,81,81,82,81,82,81,81,82,81,81,82,81,82};

  task automatic test_reset();
    reset = 1'b0;
    enable = 1'b0;
    step();
    tests_run++;
    if ({sample_tick, bit_tick, mid_tick, cfg_pending, cfg_err} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs got %b want 00000",
               {sample_tick, bit_tick, mid_tick, cfg_pending, cfg_err});
    end
  endtask

  task automatic test_default();
    int n, want, span;
    span = 0;
    reset = 1'b1;
    enable = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      wait_tick(n);
      want = (k == 1) ? 81 : gaps[k-2];
      if (k >= 2) span += n;
      tests_run++;
      if (n !== want) begin
        tests_failed++;
        $display("FAIL default_gap[%0d] got %0d want %0d", k, n, want);
      end
      if (k <= 16) begin
        tests_run++;
        if (mid_tick !== (k == 8) || bit_tick !== (k == 16)) begin
          tests_failed++;
          $display("FAIL default_mid_bit[%0d] got mid=%b bit=%b want mid=%b bit=%b",
                   k, mid_tick, bit_tick, (k == 8), (k == 16));
        end
      end
    end
    tests_run++;
    if (span !== 1302) begin
      tests_failed++;
      $display("FAIL default_span16 got %0d want 1302", span);
    end
  endtask

  task automatic test_div_change();
    int n, span;
    bit found;
    step_n(30);
    write_div(4, 0);
    tests_run++;
    if (cfg_pending !== 1'b1) begin
      tests_failed++;
      $display("FAIL div4_pending_set got %b want 1", cfg_pending);
    end
    wait_tick(n);
    tests_run++;
    if (n !== 50 || cfg_pending !== 1'b0) begin
      tests_failed++;
      $display("FAIL div4_apply got gap=%0d pend=%b want gap=50 pend=0", n, cfg_pending);
    end
    for (int i = 0; i < 4; i++) begin
      wait_tick(n);
      tests_run++;
      if (n !== 4) begin
        tests_failed++;
        $display("FAIL div4_gap[%0d] got %0d want 4", i, n);
      end
    end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      wait_tick(n);
      if (bit_tick) found = 1'b1;
    end
    span = 0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      wait_tick(n);
      span += n;
      if (bit_tick) found = 1'b1;
    end
    tests_run++;
    if (span !== 64) begin
      tests_failed++;
      $display("FAIL div4_bit_period got %0d want 64", span);
    end
  endtask

  task automatic test_int1();
    int n, cyc;
    bit found;
    write_div(1, 0);
    wait_tick(n);
    for (int i = 0; i < 32; i++) begin
      step();
      tests_run++;
      if (sample_tick !== 1'b1) begin
        tests_failed++;
        $display("FAIL int1_continuous[%0d] got %b want 1", i, sample_tick);
      end
    end
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (bit_tick) found = 1'b1;
    end
    cyc = -1;
    found = 1'b0;
    for (int i = 1; i <= 40 && !found; i++) begin
      step();
      if (bit_tick) begin
        cyc = i;
        found = 1'b1;
      end
    end
    tests_run++;
    if (cyc !== 16) begin
      tests_failed++;
      $display("FAIL int1_bit_period got %0d want 16", cyc);
    end
  endtask

  task automatic test_cfg_err();
    int n;
    write_div(4, 0);
    wait_tick(n);
    wait_tick(n);
    tests_run++;
    if (n !== 4) begin
      tests_failed++;
      $display("FAIL err_setup_gap got %0d want 4", n);
    end
    div_int = 16'd0;
    div_wr = 1'b1;
    step();
    div_wr = 1'b0;
    tests_run++;
    if (cfg_err !== 1'b1 || cfg_pending !== 1'b0 || sample_tick !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_pulse got err=%b pend=%b tick=%b want 1 0 0",
               cfg_err, cfg_pending, sample_tick);
    end
    step();
    tests_run++;
    if (cfg_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_one_cycle got %b want 0", cfg_err);
    end
    wait_tick(n);
    tests_run++;
    if (n !== 2) begin
      tests_failed++;
      $display("FAIL err_period_kept got %0d want 2", n);
    end
    write_div(5, 0);
    div_int = 16'd0;
    div_wr = 1'b1;
    step();
    div_wr = 1'b0;
    tests_run++;
    if (cfg_err !== 1'b1 || cfg_pending !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_while_pending got err=%b pend=%b want 1 1", cfg_err, cfg_pending);
    end
    wait_tick(n);
    tests_run++;
    if (n !== 2 || cfg_pending !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_shadow_apply got gap=%0d pend=%b want 2 0", n, cfg_pending);
    end
    wait_tick(n);
    tests_run++;
    if (n !== 5) begin
      tests_failed++;
      $display("FAIL err_shadow_kept got %0d want 5", n);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    write_div(3, 0);
    step_n(3);
    write_div(6, 0);
    tests_run++;
    if (sample_tick !== 1'b1 || cfg_pending !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_coincident got tick=%b pend=%b want 1 1", sample_tick, cfg_pending);
    end
    wait_tick(n);
    tests_run++;
    if (n !== 3 || cfg_pending !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_first got gap=%0d pend=%b want 3 0", n, cfg_pending);
    end
    wait_tick(n);
    tests_run++;
    if (n !== 6) begin
      tests_failed++;
      $display("FAIL b2b_second got %0d want 6", n);
    end
  endtask

  task automatic test_enable_resync();
    int n;
    write_div(81, 0);
    wait_tick(n);
    tests_run++;
    if (n !== 5) begin
      tests_failed++;
      $display("FAIL en_setup_apply got %0d want 5", n);
    end
    wait_tick(n);
    tests_run++;
    if (n !== 81) begin
      tests_failed++;
      $display("FAIL en_setup_gap got %0d want 81", n);
    end
    step_n(20);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      tests_run++;
      if ({sample_tick, bit_tick, mid_tick} !== 3'b000) begin
        tests_failed++;
        $display("FAIL en_hold_quiet[%0d] got %b want 000", i, {sample_tick, bit_tick, mid_tick});
      end
    end
    enable = 1'b1;
    wait_tick(n);
    tests_run++;
    if (20 + 10 + n !== 91) begin
      tests_failed++;
      $display("FAIL en_delay got %0d want 91", 30 + n);
    end
    step_n(40);
    resync = 1'b1;
    step();
    resync = 1'b0;
    tests_run++;
    if (sample_tick !== 1'b0) begin
      tests_failed++;
      $display("FAIL resync_no_tick got %b want 0", sample_tick);
    end
    for (int k = 1; k <= 16; k++) begin
      wait_tick(n);
      tests_run++;
      if (n !== 81 || mid_tick !== (k == 8) || bit_tick !== (k == 16)) begin
        tests_failed++;
        $display("FAIL resync_tick[%0d] got gap=%0d mid=%b bit=%b want 81 %b %b",
                 k, n, mid_tick, bit_tick, (k == 8), (k == 16));
      end
    end
    step_n(80);
    resync = 1'b1;
    step();
    resync = 1'b0;
    tests_run++;
    if (sample_tick !== 1'b0) begin
      tests_failed++;
      $display("FAIL resync_priority got %b want 0", sample_tick);
    end
    wait_tick(n);
    tests_run++;
    if (n !== 81) begin
      tests_failed++;
      $display("FAIL resync_priority_gap got %0d want 81", n);
    end
  endtask

  task automatic test_reset_mid();
    int n, want;
    step_n(10);
    write_div(4, 0);
    tests_run++;
    if (cfg_pending !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_pending_set got %b want 1", cfg_pending);
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    tests_run++;
    if ({sample_tick, bit_tick, mid_tick, cfg_pending, cfg_err} !== 5'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_outputs got %b want 00000",
               {sample_tick, bit_tick, mid_tick, cfg_pending, cfg_err});
    end
    for (int k = 1; k <= 8; k++) begin
      wait_tick(n);
      want = (k == 1) ? 81 : gaps[k-2];
      tests_run++;
      if (n !== want || mid_tick !== (k == 8)) begin
        tests_failed++;
        $display("FAIL rst_default_gap[%0d] got gap=%0d mid=%b want %0d %b",
                 k, n, mid_tick, want, (k == 8));
      end
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_div_change();
    test_int1();
    test_cfg_err();
    test_back_to_back();
    test_enable_resync();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
